// File: rtl/bus_arbiter_mux_if.sv
// Common-bus handshake bundle: source requests and words in, registered bus word and grant strobes out.
// The slave modport faces the arbiter and the master modport faces the sources and consumer.
interface bus_arbiter_mux_if #(
    parameter int WIDTH   = 16,
    parameter int SOURCES = 8,
    localparam int SEL_W  = $clog2(SOURCES)
);
    logic [SOURCES-1:0]       req;
    logic [SOURCES*WIDTH-1:0] data_in;
    logic                     force_en;
    logic [SEL_W-1:0]         force_sel;
    logic                     bus_ready;
    logic [WIDTH-1:0]         bus_out;
    logic                     bus_valid;
    logic [SEL_W-1:0]         bus_id;
    logic [SOURCES-1:0]       grant;
    logic                     sel_err;

    modport master (
        output req, data_in, force_en, force_sel, bus_ready,
        input  bus_out, bus_valid, bus_id, grant, sel_err
    );

    modport slave (
        input  req, data_in, force_en, force_sel, bus_ready,
        output bus_out, bus_valid, bus_id, grant, sel_err
    );
endinterface

// File: rtl/bus_arbiter_mux.sv
// Round-robin common-bus mux with a legacy force-select mode; 1-cycle latency from request to a registered word.
// The output register holds its word while bus_valid=1 and bus_ready=0; grant is 0 whenever no load is possible.
module bus_arbiter_mux #(
    parameter int WIDTH   = 16,
    parameter int SOURCES = 8,
    localparam int SEL_W  = $clog2(SOURCES)
) (
    input  logic              clk,
    input  logic              rst_n,
    bus_arbiter_mux_if.slave  bif
);
    localparam logic [SEL_W:0] SRC_N = (SEL_W+1)'(SOURCES);

    logic [SEL_W-1:0]   rr_ptr;
    logic [SEL_W-1:0]   rr_win;
    logic [SEL_W-1:0]   cap_idx;
    logic [SEL_W:0]     cand;
    logic [WIDTH-1:0]   cap_word;
    logic [SOURCES-1:0] grant_c;
    logic               load_ok;
    logic               rr_found;
    logic               cap;
    logic               err_nxt;

    assign load_ok  = !bif.bus_valid || bif.bus_ready;
    assign bif.grant = grant_c;

    // Search rr_ptr+1, rr_ptr+2, ... with a modulo-SOURCES wrap so unused codes are never visited.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        cand     = '0;
        for (int k = 1; k <= SOURCES; k++) begin
            cand = {1'b0, rr_ptr} + (SEL_W+1)'(k);
            if (cand >= SRC_N) cand = cand - SRC_N;
            if (!rr_found && bif.req[cand[SEL_W-1:0]]) begin
                rr_found = 1'b1;
                rr_win   = cand[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        cap     = 1'b0;
        err_nxt = 1'b0;
        cap_idx = rr_win;
        if (bif.force_en) begin
            cap_idx = bif.force_sel;
            if ({1'b0, bif.force_sel} < SRC_N) cap = load_ok;
            else                               err_nxt = load_ok;
        end else begin
            cap = load_ok && rr_found;
        end
    end

    always_comb begin
        cap_word = '0;
        grant_c  = '0;
        for (int i = 0; i < SOURCES; i++) begin
            if (cap_idx == SEL_W'(i)) begin
                cap_word   = bif.data_in[i*WIDTH +: WIDTH];
                grant_c[i] = cap;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bif.bus_out   <= '0;
            bif.bus_valid <= 1'b0;
            bif.bus_id    <= '0;
            bif.sel_err   <= 1'b0;
            rr_ptr        <= SEL_W'(SOURCES - 1);
        end else begin
            bif.sel_err <= err_nxt;
            if (load_ok) begin
                bif.bus_valid <= cap;
                if (cap) begin
                    bif.bus_out <= cap_word;
                    bif.bus_id  <= cap_idx;
                    // Forced loads leave the fairness pointer untouched.
                    if (!bif.force_en) rr_ptr <= cap_idx;
                end
            end
        end
    end
endmodule
